// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM state codes,
// the per-master request bundle and width helpers.
package wb_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWN   = 2'd1;
    localparam arb_state_t ST_ABORT = 2'd2;

    // Everything the slave sees from the owning master apart from cyc/stb.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Watchdog counter width; a disabled watchdog still gets a 1-bit stub.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr,
// wrapping modulo NUM_M.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int NUM_M = 2,
    localparam int IDX_W = clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the block leaves it holding a stale value (no latch).
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_M)) begin
                sum = sum - SUM_W'(NUM_M);
            end
            cand = sum[IDX_W-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one whole cyc tenure per grant, slave
// responses routed only to the owner, watchdog abort for silent slaves.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [NUM_M*32-1:0] m_adr_i,
    input  logic [NUM_M*32-1:0] m_dat_i,
    input  logic [NUM_M*4-1:0]  m_sel_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    output logic [31:0]         m_dat_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,

    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [31:0]         s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,

    output logic [NUM_M-1:0]    gnt_o,
    output logic                busy_o
);

    localparam int IDX_W = clog2(NUM_M);
    localparam int CNT_W = cnt_width(TIMEOUT);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_M-1:0] gnt_q, gnt_d;
    logic             abort_err_q, abort_err_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    wb_req_t          req_a [NUM_M];
    wb_req_t          own_req;
    logic             own_cyc;
    logic             own_stb;
    logic             stall;
    logic             wd_fire;
    logic [IDX_W-1:0] next_ptr;

    for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
        assign req_a[k] = {m_adr_i[32*k +: 32], m_dat_i[32*k +: 32],
                           m_sel_i[4*k +: 4], m_we_i[k]};
    end

    wb_rr_pick #(
        .NUM_M (NUM_M)
    ) u_pick (
        .req   (m_cyc_i),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // stb without cyc is not a Wishbone request, so it never reaches the slave.
    assign own_req  = req_a[g_q];
    assign own_cyc  = m_cyc_i[g_q];
    assign own_stb  = m_stb_i[g_q] & own_cyc;
    assign stall    = (state_q == ST_OWN) && own_stb && !s_ack_i && !s_err_i;
    assign wd_fire  = (TIMEOUT > 0) && stall && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign next_ptr = (g_q == IDX_W'(NUM_M - 1)) ? '0 : g_q + IDX_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            abort_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values sampled at this edge, independent of statement order.
            state_q     <= state_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            abort_err_q <= abort_err_d;
        end
    end

    // Next-state logic; the watchdog count falls back to zero by default.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = '0;
        abort_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_OWN;
                    g_d     = pick_idx;
                    gnt_d   = NUM_M'(1) << pick_idx;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                    gnt_d   = '0;
                end else if (wd_fire) begin
                    state_d     = ST_ABORT;
                    abort_err_d = 1'b1;
                end else if (stall && (TIMEOUT > 0)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output logic: slave side follows the owner only while in OWN.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        case (state_q)
            ST_OWN: begin
                s_adr_o = own_req.adr;
                s_dat_o = own_req.dat;
                s_sel_o = own_req.sel;
                s_we_o  = own_req.we;
                s_cyc_o = own_cyc;
                s_stb_o = own_stb;
                m_ack_o = gnt_q & {NUM_M{s_ack_i}};
                m_err_o = gnt_q & {NUM_M{s_err_i}};
            end
            ST_ABORT: begin
                // Slave responses are dropped here; only the one-cycle abort error reaches the owner.
                m_err_o = gnt_q & {NUM_M{abort_err_q}};
            end
            default: ;
        endcase
    end

    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;
    assign busy_o  = (state_q == ST_OWN) || (state_q == ST_ABORT);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed checks on a 2-master instance without
// watchdog, then randomized rounds on a 3-master instance with TIMEOUT=8.
module tb_wb_rr_arbiter;

    localparam int NM     = 3;
    localparam int TO     = 8;
    localparam int ROUNDS = 120;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: 3 masters, watchdog 8 ----------------
    logic                rst;
    logic [NM*32-1:0]    a_adr, a_dat;
    logic [NM*4-1:0]     a_sel;
    logic [NM-1:0]       a_we, a_cyc, a_stb;
    logic [31:0]         a_mdat;
    logic [NM-1:0]       a_ack, a_err, a_gnt;
    logic [31:0]         a_sadr, a_sdat, a_sdi;
    logic [3:0]          a_ssel;
    logic                a_swe, a_scyc, a_sstb, a_sack, a_serr, a_busy;

    wb_rr_arbiter #(.NUM_M(NM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(a_adr), .m_dat_i(a_dat), .m_sel_i(a_sel),
        .m_we_i(a_we), .m_cyc_i(a_cyc), .m_stb_i(a_stb),
        .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err),
        .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_sel_o(a_ssel),
        .s_we_o(a_swe), .s_cyc_o(a_scyc), .s_stb_o(a_sstb),
        .s_dat_i(a_sdi), .s_ack_i(a_sack), .s_err_i(a_serr),
        .gnt_o(a_gnt), .busy_o(a_busy)
    );

    // ---------------- instance B: 2 masters, watchdog off ----------------
    logic                rst2;
    logic [63:0]         b_adr, b_dat;
    logic [7:0]          b_sel;
    logic [1:0]          b_we, b_cyc, b_stb;
    logic [31:0]         b_mdat;
    logic [1:0]          b_ack, b_err, b_gnt;
    logic [31:0]         b_sadr, b_sdat, b_sdi;
    logic [3:0]          b_ssel;
    logic                b_swe, b_scyc, b_sstb, b_sack, b_serr, b_busy;

    wb_rr_arbiter #(.NUM_M(2), .TIMEOUT(0)) dut_nowd (
        .clk(clk), .rst(rst2),
        .m_adr_i(b_adr), .m_dat_i(b_dat), .m_sel_i(b_sel),
        .m_we_i(b_we), .m_cyc_i(b_cyc), .m_stb_i(b_stb),
        .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err),
        .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_sel_o(b_ssel),
        .s_we_o(b_swe), .s_cyc_o(b_scyc), .s_stb_o(b_sstb),
        .s_dat_i(b_sdi), .s_ack_i(b_sack), .s_err_i(b_serr),
        .gnt_o(b_gnt), .busy_o(b_busy)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [NM-1:0] oh(input int m);
        return NM'(1) << m;
    endfunction

    // resp: 0 = ack, 1 = slave err, 2 = silent slave (watchdog abort)
    typedef struct {
        int          m;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          resp;
        int          delay;
        bit          last;
    } beat_t;

    beat_t mq [NM][$];
    beat_t exp_q [$];
    beat_t slv_q [$];

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    int stb_start = 0;

    // ---------------- scoreboard monitor (instance A) ----------------
    logic [NM-1:0] prev_gnt = '0;
    beat_t         me;

    always @(negedge clk) begin
        if (rst) begin
            check("busy_vs_gnt", a_busy, a_gnt != 0);
            if (a_gnt != prev_gnt && a_gnt != 0) check("idle_gap", prev_gnt, 0);
            prev_gnt = a_gnt;
            if (a_gnt == 0) check("s_idle", {a_scyc, a_sstb, a_sadr}, 0);
            if (a_sack || a_serr) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_response");
                end else begin
                    me = exp_q.pop_front();
                    check("beat_gnt", a_gnt, oh(me.m));
                    check("beat_adr", a_sadr, me.adr);
                    check("beat_dat", a_sdat, me.dat);
                    check("beat_sel_we", {a_ssel, a_swe}, {me.sel, me.we});
                    check("beat_cyc_stb", {a_scyc, a_sstb}, 2'b11);
                    check("beat_ack", a_ack, (me.resp == 0) ? oh(me.m) : '0);
                    check("beat_err", a_err, (me.resp == 1) ? oh(me.m) : '0);
                    check("beat_rdata", a_mdat, a_sdi);
                end
            end else if (a_err != 0) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_abort");
                end else begin
                    me = exp_q.pop_front();
                    check("abort_kind", me.resp, 2);
                    check("abort_err", a_err, oh(me.m));
                    check("abort_gnt", a_gnt, oh(me.m));
                    check("abort_time", cyc_n - stb_start, TO);
                    check("abort_scyc", {a_scyc, a_sstb}, 0);
                end
            end else begin
                check("no_term", a_ack, 0);
            end
        end
    end

    // ---------------- stimulus state (instance A) ----------------
    int    ptr_m = 0;
    int    outstanding = 0;
    bit    go [NM];
    int    mst_st [NM];
    int    wait_n [NM];
    bit    term [NM];
    beat_t cur [NM];
    bit    s_active = 0;
    int    s_wcnt = 0;
    beat_t s_cur;
    int    dtab [5] = '{0, 1, 2, 3, TO - 1};

    task automatic drive_m(input int k, input beat_t b);
        a_adr[32*k +: 32] = b.adr;
        a_dat[32*k +: 32] = b.dat;
        a_sel[4*k +: 4]   = b.sel;
        a_we[k]           = b.we;
    endtask

    // Reference order: rotate from the pointer through the requesting set,
    // each master served once, pointer lands just after the last one served.
    task automatic gen_round();
        logic [NM-1:0] remaining;
        int            p, k, nb, r;
        bit            found;
        beat_t         b;
        remaining = NM'($urandom_range(1, (1 << NM) - 1));
        p = ptr_m;
        while (remaining != 0) begin
            k = 0;
            found = 0;
            for (int s = 0; s < NM; s++) begin
                if (!found && remaining[(p + s) % NM]) begin
                    k = (p + s) % NM;
                    found = 1;
                end
            end
            remaining[k] = 1'b0;
            p = (k + 1) % NM;
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                r       = $urandom_range(0, 99);
                b.m     = k;
                b.adr   = $urandom;
                b.dat   = $urandom;
                b.sel   = 4'($urandom);
                b.we    = 1'($urandom);
                b.resp  = (r < 70) ? 0 : (r < 85) ? 1 : 2;
                b.delay = dtab[$urandom_range(0, 4)];
                b.last  = (i == nb - 1) || (b.resp != 0);
                mq[k].push_back(b);
                exp_q.push_back(b);
                slv_q.push_back(b);
                if (b.last) break;
            end
            go[k] = 1;
            outstanding++;
        end
        ptr_m = p;
    endtask

    // ---------------- main sequence ----------------
    int rounds;
    int bad;

    initial begin
        rst = 1'b0;  rst2 = 1'b0;
        a_adr = '0;  a_dat = '0; a_sel = '0; a_we = '0; a_cyc = '0; a_stb = '0;
        a_sdi = '0;  a_sack = 1'b0; a_serr = 1'b0;
        b_adr = '0;  b_dat = '0; b_sel = '0; b_we = '0; b_cyc = '0; b_stb = '0;
        b_sdi = 32'h1234_5678; b_sack = 1'b0; b_serr = 1'b0;
        for (int k = 0; k < NM; k++) begin
            go[k] = 0; mst_st[k] = 0; wait_n[k] = 0; term[k] = 0;
        end

        // Reset values on instance B.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt_busy", {b_gnt, b_busy}, 0);
        check("rst_s_out", {b_sadr, b_sdat, b_ssel, b_swe, b_scyc, b_sstb}, 0);
        check("rst_ack_err", {b_ack, b_err}, 0);
        check("rst_mdat", b_mdat, 32'h1234_5678);
        @(posedge clk); #2;
        rst = 1'b1; rst2 = 1'b1;

        // Single master: one-cycle arbitration latency, ack routed in its cycle.
        @(posedge clk); #1;
        b_cyc = 2'b01; b_stb = 2'b01; b_we = 2'b01; b_sel = 8'h0F;
        b_adr[31:0] = 32'hC0DE_0000; b_dat[31:0] = 32'hDA7A_0001;
        @(negedge clk);
        check("lat_cycle0_scyc", b_scyc, 1'b0);
        @(negedge clk);
        check("lat_cycle1_scyc", {b_scyc, b_sstb}, 2'b11);
        check("single_gnt", b_gnt, 2'b01);
        check("single_adr_dat", {b_sadr, b_sdat}, {32'hC0DE_0000, 32'hDA7A_0001});
        check("single_busy", b_busy, 1'b1);
        @(negedge clk);
        check("single_no_ack_early", b_ack, 2'b00);
        @(posedge clk); #1;
        b_sack = 1'b1;
        @(negedge clk);
        check("single_ack", b_ack, 2'b01);
        @(posedge clk); #1;
        b_sack = 1'b0; b_cyc = 2'b00; b_stb = 2'b00;
        @(negedge clk);
        check("single_ack_gone", b_ack, 2'b00);
        @(negedge clk);
        check("single_release", {b_gnt, b_scyc, b_busy}, 0);

        // Watchdog disabled: silent slave, grant must be held with no err.
        @(posedge clk); #1;
        b_cyc = 2'b10; b_stb = 2'b10;
        @(negedge clk);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (b_err != 0 || b_gnt != 2'b10 || !b_scyc || !b_busy) bad++;
        end
        check("wd_off_hold", bad, 0);

        // Reset mid-tenure: outputs drop without a clock edge; master 0 wins next.
        @(posedge clk); #1;
        b_cyc = 2'b11; b_stb = 2'b11;
        @(negedge clk); #2;
        rst2 = 1'b0;
        #1;
        check("midrst_async", {b_scyc, b_gnt, b_busy}, 0);
        @(posedge clk); #2;
        rst2 = 1'b1;
        @(negedge clk);
        check("postrst_idle", b_gnt, 2'b00);
        @(negedge clk);
        check("postrst_gnt", b_gnt, 2'b01);
        @(posedge clk); #1;
        b_cyc = 2'b00; b_stb = 2'b00;

        // Randomized rounds on instance A.
        rounds = 0;
        for (int c = 0; c < 30000 && (rounds < ROUNDS || outstanding > 0); c++) begin
            @(negedge clk);
            for (int k = 0; k < NM; k++) term[k] = a_ack[k] | a_err[k];
            @(posedge clk); #1;
            if (outstanding == 0 && rounds < ROUNDS) begin
                gen_round();
                rounds++;
            end
            for (int k = 0; k < NM; k++) begin
                if (mst_st[k] == 0) begin
                    if (go[k]) begin
                        go[k] = 0;
                        cur[k] = mq[k].pop_front();
                        drive_m(k, cur[k]);
                        a_cyc[k] = 1'b1; a_stb[k] = 1'b1;
                        mst_st[k] = 1; wait_n[k] = 0;
                    end
                end else if (term[k]) begin
                    wait_n[k] = 0;
                    if (cur[k].last || mq[k].size() == 0) begin
                        a_cyc[k] = 1'b0; a_stb[k] = 1'b0;
                        a_adr[32*k +: 32] = $urandom;
                        mst_st[k] = 0;
                        outstanding--;
                    end else begin
                        cur[k] = mq[k].pop_front();
                        drive_m(k, cur[k]);
                    end
                end else begin
                    wait_n[k]++;
                    if (wait_n[k] > 200) begin
                        fail($sformatf("master%0d_no_termination", k));
                        a_cyc[k] = 1'b0; a_stb[k] = 1'b0;
                        mq[k].delete();
                        mst_st[k] = 0;
                        outstanding--;
                    end
                end
            end
            #1;
            a_sack = 1'b0; a_serr = 1'b0; a_sdi = $urandom;
            if (a_scyc && a_sstb) begin
                if (!s_active) begin
                    if (slv_q.size() == 0) begin
                        fail("slave_unexpected_strobe");
                    end else begin
                        s_cur = slv_q.pop_front();
                        s_active = 1; s_wcnt = 0; stb_start = cyc_n;
                    end
                end
                if (s_active) begin
                    if (s_cur.resp != 2 && s_wcnt == s_cur.delay) begin
                        if (s_cur.resp == 0) a_sack = 1'b1;
                        else                 a_serr = 1'b1;
                        s_active = 0;
                    end else begin
                        s_wcnt++;
                    end
                end
            end else begin
                s_active = 0;
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rounds_done", rounds, ROUNDS);
        check("all_tenures_closed", outstanding, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("slave_plan_drained", slv_q.size(), 0);
        check("final_idle", {a_gnt, a_busy, a_scyc}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one slave port between NUM_M masters, such as the LM32 data port and a future DMA/sampling engine contending for spi0 or the trigger unit. It grants a whole bus tenure (from `cyc` rise to `cyc` fall) to one master at a time and routes `ack`/`err` only to that master. A watchdog aborts tenures whose slave never acknowledges, so a hung peripheral cannot stall the SoC.

## Interface
- `NUM_M`, 2: number of masters, 2..8.
- `TIMEOUT`, 255: unacknowledged-strobe cycles before abort; 0 disables the watchdog.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `m_adr_i` in NUM_M*32: master addresses, master k at [32k+31:32k].
- `m_dat_i` in NUM_M*32: master write data, same packing.
- `m_sel_i` in NUM_M*4: master byte selects.
- `m_we_i`, `m_cyc_i`, `m_stb_i` in NUM_M: per-master controls.
- `m_dat_o` out 32: `s_dat_i` broadcast to all masters.
- `m_ack_o`, `m_err_o` out NUM_M: per-master termination.
- `s_adr_o` out 32, `s_dat_o` out 32, `s_sel_o` out 4, `s_we_o`/`s_cyc_o`/`s_stb_o` out 1: slave-side request.
- `s_dat_i` in 32, `s_ack_i` in 1, `s_err_i` in 1: slave response.
- `gnt_o` out NUM_M: one-hot current owner; all zero when no master owns the bus.
- `busy_o` out 1: high in OWN and ABORT.

## Operation
- **State machine states:** IDLE, OWN, ABORT.
- **Grant register:** `g` (index) plus pointer `ptr` (next-priority index).
- **IDLE:**
  - Choose the first k with `m_cyc_i[k]=1`, searching `ptr`, `ptr+1`, … mod NUM_M.
  - On the next edge, load `g=k` and `gnt_o=onehot(k)`, then enter OWN.
  - If no master requests, stay in IDLE.
- **OWN:**
  - `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o` and `s_stb_o` are combinationally muxed from master `g`.
  - `m_ack_o[g]=s_ack_i` and `m_err_o[g]=s_err_i`.
  - All other masters see ack=err=0.
  - The grant is held while `m_cyc_i[g]=1`, across any number of `stb` beats.
  - When `m_cyc_i[g]=0` is sampled, the next state is IDLE and `ptr=(g+1) mod NUM_M`.
- **Watchdog (TIMEOUT>0):**
  - Counter `cnt` is clog2(TIMEOUT+1) bits.
  - `cnt` increments each OWN cycle with `s_stb_o=1` and `s_ack_i=0` and `s_err_i=0`.
  - `cnt` clears on ack, on err, on `stb` low, and on leaving OWN.
  - When the edge samples `cnt==TIMEOUT-1` with the stall condition still true, the next state is ABORT.
- **ABORT:**
  - `s_cyc_o=s_stb_o=0`.
  - `m_err_o[g]=1` for exactly the first ABORT cycle, then 0.
  - Stay in ABORT until `m_cyc_i[g]=0` is sampled, then go to IDLE with `ptr=(g+1) mod NUM_M`.
- **Outside OWN:** all `s_*` outputs are 0.
- **Masters not granted:** no side effects; a non-owner may drop or raise `cyc` freely.

## Timing
- **Reset values:**
  - State IDLE; `ptr=0`, `cnt=0`, `gnt_o=0`, `busy_o=0`.
  - All `s_*` outputs 0; all `m_ack_o`/`m_err_o` 0; `m_dat_o=s_dat_i`.
- **Reset mid-tenure:** asserting `rst` drops `s_cyc_o` immediately (asynchronously); any in-flight ack is lost.
- **Arbitration latency:** `s_cyc_o` rises 1 cycle after `m_cyc_i` is first sampled high with the bus idle.
- **Slave to master path:** `ack`/`err` are combinational, 0 added latency.
- **Between tenures:** at least one cycle with `s_cyc_o=0`, because release always passes through IDLE.
- **Abort timing:** with `stb` first high in cycle 0 and never acked, cycles 0..TIMEOUT-1 are in OWN and the err pulse is in cycle TIMEOUT.
- **Simultaneous events:**
  - An ack in cycle TIMEOUT-1 wins; no abort occurs.
  - An ack during ABORT is ignored.
  - `s_err_i` is never suppressed in OWN.
- **Simultaneous requests in IDLE:** resolved purely by `ptr`; no master can be granted twice in a row while another master is waiting.

## Structure
- Package `wb_arb_pkg`:
  - State encoding constants ST_IDLE=2'd0, ST_OWN=2'd1, ST_ABORT=2'd2.
  - Function `clog2`.
- Sub-module `wb_rr_pick`:
  - Combinational rotating-priority encoder.
  - Inputs: `req[NUM_M]`, `ptr`.
  - Outputs: `idx`, `valid`.
- Top level holds the FSM, watchdog counter and the data/control muxes.

## Test plan
- **Single master:** after reset, master 0 raises cyc/stb and the slave acks 2 cycles later -> `s_cyc_o` rises 1 cycle after `m_cyc_i`, `gnt_o=2'b01`, `m_ack_o=2'b01` exactly in the ack cycle.
- **Contention:** both masters hold cyc continuously with 1-beat tenures -> grants alternate 0,1,0,1, with one idle bus cycle between tenures.
- **Burst hold:** master 1 holds cyc across 4 acked beats while master 0 requests -> `gnt_o` stays `2'b10` until master 1 cyc falls, then switches to `2'b01`.
- **Watchdog:** TIMEOUT=8, slave never acks, stb in cycle 0 -> `m_err_o[g]` high only in cycle 8, `s_cyc_o=0` from cycle 8; ack in cycle 7 instead -> no err.
- **Watchdog disabled:** TIMEOUT=0 with a silent slave for 1000 cycles -> no err and grant held.
- **Reset mid-tenure:** `rst` low during OWN -> `s_cyc_o`, `gnt_o` and `busy_o` go to 0 without waiting for `clk`; after release, the first grant goes to master 0.
